// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, Rcon table,
// round count and key-schedule state encoding.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_EXPAND = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  // Byte 0x00 of the S-box sits in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup, one byte in,
// one byte out.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = sbox(in_byte);

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per
// cycle into an 11-entry register file, read by index.
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          IN_valid,
  input  logic [KW-1:0] IN_key,
  output logic          IN_ready,
  output logic          KEY_ready,
  input  logic [3:0]    rd_round,
  output logic [KW-1:0] RoundKey
);

  state_t        state_q;
  state_t        state_d;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_d;
  logic [KW-1:0] keys_q [NR+1];
  logic [KW-1:0] keys_d [NR+1];

  logic [KW-1:0] prev_key;
  logic [KW-1:0] new_key;
  logic [31:0]   w0, w1, w2, w3;
  logic [31:0]   rot_w;
  logic [31:0]   sub_w;
  logic [31:0]   t_w;
  logic [31:0]   n0, n1, n2, n3;

  // Previous round key: the entry just below the write slot.
  always_comb begin
    prev_key = '0;
    for (int i = 0; i <= NR; i++) begin
      if (cnt_q == 4'(i + 1)) prev_key = keys_q[i];
    end
  end

  assign w0    = prev_key[127:96];
  assign w1    = prev_key[95:64];
  assign w2    = prev_key[63:32];
  assign w3    = prev_key[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (
      .in_byte  (rot_w[8*b +: 8]),
      .out_byte (sub_w[8*b +: 8])
    );
  end

  assign t_w     = sub_w ^ {rcon(cnt_q), 24'h0};
  assign n0      = w0 ^ t_w;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign new_key = {n0, n1, n2, n3};

  // Schedule control: load a key, then fill one entry per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    keys_d  = keys_q;
    unique case (1'b1)
      (state_q == ST_EXPAND): begin
        for (int i = 1; i <= NR; i++) begin
          if (cnt_q == 4'(i)) keys_d[i] = new_key;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NR)) state_d = ST_DONE;
      end
      default: begin
        if (IN_valid) begin
          keys_d[0] = IN_key;
          cnt_d     = 4'd1;
          state_d   = ST_EXPAND;
        end
      end
    endcase
  end

  // State, counter and key storage; reset wipes the whole schedule.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int i = 0; i <= NR; i++) keys_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      keys_q  <= keys_d;
    end
  end

  // Zero-latency read port; out-of-range indices read as zero.
  always_comb begin
    RoundKey = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rd_round == 4'(i)) RoundKey = keys_q[i];
    end
  end

  assign IN_ready  = (state_q != ST_EXPAND);
  assign KEY_ready = (state_q == ST_DONE);

endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Iterative AES-128 key schedule that feeds the AddRoundKey stage.
- Accepts one 128-bit cipher key and derives round keys 1..10, one per clock cycle.
- Stores all 11 round keys in an internal register file.
- The round controller reads any stored key combinationally, by round index, as the RoundKey operand of AddRoundKey.

Parameters:
- NR, 10, number of rounds (fixed for AES-128; any other value is unsupported).
- KW, 128, key and round-key width in bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- IN_valid  input  1  new cipher key present on IN_key
- IN_key  input  128  cipher key; byte 0 is bits [127:120]
- IN_ready  output  1  block can accept a key (state IDLE or DONE)
- KEY_ready  output  1  all 11 round keys are valid
- rd_round  input  4  round-key index to read, 0..10
- RoundKey  output  128  round key selected by rd_round (combinational)

Behaviour:
- Single clock domain, clk only. Reset is synchronous and active-high: sampled on the rising edge of clk.
- Reset values:
  - state = IDLE, round counter = 0.
  - IN_ready = 1, KEY_ready = 0.
  - All 11 storage entries = 0, so RoundKey = 0.
- FSM states: IDLE, EXPAND, DONE.
  - IDLE: IN_ready = 1, KEY_ready = 0.
  - IDLE to EXPAND on the edge where IN_valid = 1. At that edge: IN_key is written to entry 0, and the counter is set to 1.
  - EXPAND: IN_ready = 0, KEY_ready = 0. IN_valid is ignored; the key is not queued.
  - Each EXPAND cycle: entry[cnt] = f(entry[cnt-1], Rcon[cnt]); cnt increments.
  - EXPAND to DONE on the edge that writes entry 10.
  - DONE: IN_ready = 1, KEY_ready = 1. Outputs are registered and state-decoded.
  - DONE to EXPAND when IN_valid = 1, with the same load actions as in IDLE. KEY_ready drops on the same edge.
- Latency: key accepted at edge 0; entry k is written at edge k; KEY_ready is high from edge 10 onward. Total 11 edges from acceptance to use, 10 of them in EXPAND.
- Round function, with previous key words w0..w3 and w0 = bits [127:96]:
  - t = SubWord(RotWord(w3)) XOR {Rcon[cnt], 24'h0}.
  - RotWord(x) = {x[23:0], x[31:24]}.
  - SubWord applies the AES S-box to each byte.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - New key = {n0, n1, n2, n3}.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 (hex).
- Read port: RoundKey = entry[rd_round] when rd_round <= 10; RoundKey = 0 when rd_round is 11..15. There is no read latency.
- Reads before KEY_ready return the current register contents. These are deterministic but not meaningful; consumers must gate on KEY_ready.
- Reset mid-EXPAND: state returns to IDLE and all entries are cleared on that edge. The partial schedule is discarded.
- Reset has priority over IN_valid when both are high on the same edge.
- A new key loaded from DONE overwrites entries progressively. Stale entries k+1..10 stay readable until they are overwritten, with KEY_ready = 0 meanwhile.

Decomposition:
- Shared package aes_pkg:
  - The Rcon table: 10 bytes, as a constant function or array.
  - AES_NR = 10.
  - The state-type encoding (IDLE, EXPAND, DONE).
  - The S-box table, also reused by the SubBytes stage.
- One sub-module, aes_sbox: combinational, 8-bit in, 8-bit out. The block instantiates it 4 times for SubWord.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, IN_valid pulsed from IDLE -> IN_ready low for 10 cycles; KEY_ready rises at edge 10; rd_round = 1 gives a0fafe1788542cb123a339392a6c7605; rd_round = 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rd_round = 0 gives the input key.
- All-zero key -> rd_round = 1 gives 62636363626363636263636362636363; rd_round = 10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
- IN_valid held high during EXPAND with a different key -> ignored; final keys match the first key; in DONE the still-high IN_valid starts a new expansion on the next edge.
- reset asserted at EXPAND cycle 5 -> next edge: IN_ready = 1, KEY_ready = 0, RoundKey = 0 for every rd_round; a subsequent load completes correctly.
- rd_round = 11..15 in DONE -> RoundKey = 0; IN_valid and reset asserted on the same edge -> reset wins, state stays IDLE.
- Back-to-back loads (FIPS key, then zero key issued from DONE) -> KEY_ready falls on the load edge and rises 10 edges later with the zero-key schedule.
